// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle MIPS datapath: one instruction at a time,
// registered control word per state; BRANCH gates enable_PC with the live zero flag.
module multicycle_control_unit #(
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter int          STATE_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               enable_PC,
  output logic               Selector_Addr,
  output logic               enable_MemSys,
  output logic               enable_RegIns,
  output logic               enable_RF,
  output logic               Selector_RF_WR,
  output logic               Selector_RF_WD,
  output logic               Selector_ALU_Src_A,
  output logic [1:0]         Selector_ALU_Src_B,
  output logic               Selector_Imm_Ext,
  output logic [2:0]         Selector_ALU_Op,
  output logic [1:0]         Selector_PC_Source,
  output logic               halted,
  output logic [STATE_W-1:0] state_o
);

  if (TEXT_BASE[1:0] != 2'b00 || STATE_W != 4) begin : g_bad_cfg
    $error("multicycle_control_unit: TEXT_BASE must be word aligned and STATE_W must be 4");
  end

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_I_EXEC    = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_LUI = 3'b111;

  typedef struct packed {
    logic       enable_pc;
    logic       sel_addr;
    logic       enable_mem;
    logic       enable_ir;
    logic       enable_rf;
    logic       sel_rf_wr;
    logic       sel_rf_wd;
    logic       sel_src_a;
    logic [1:0] sel_src_b;
    logic       sel_imm_ext;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   br_ne_q, br_ne_d;
  logic   r_legal;
  logic [2:0] r_alu_op;

  always_comb begin
    r_legal  = 1'b1;
    r_alu_op = OP_ADD;
    case (funct)
      6'h20, 6'h21: r_alu_op = OP_ADD;
      6'h22, 6'h23: r_alu_op = OP_SUB;
      6'h24:        r_alu_op = OP_AND;
      6'h25:        r_alu_op = OP_OR;
      6'h27:        r_alu_op = OP_NOR;
      6'h00:        r_alu_op = OP_SLL;
      6'h02:        r_alu_op = OP_SRL;
      default:      r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    br_ne_d = br_ne_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:                      state_d = r_legal ? S_R_EXEC : S_HALT;
          6'h08, 6'h09, 6'h0D, 6'h0F: state_d = S_I_EXEC;
          6'h23, 6'h2B:               state_d = S_MEM_ADDR;
          6'h04, 6'h05:               state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          default:                    state_d = S_HALT;
        endcase
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == 6'h2B) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
    // Remember BEQ vs BNE so BRANCH does not depend on the IR staying put.
    if (state_d == S_BRANCH) br_ne_d = opcode[0];
  end

  // Control word is computed for the state being entered, then registered.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.enable_pc = 1'b1;
        ctrl_d.enable_ir = 1'b1;
        ctrl_d.sel_src_b = 2'b01;
        ctrl_d.alu_op    = OP_ADD;
      end
      S_DECODE: begin
        ctrl_d.sel_src_b = 2'b11;
        ctrl_d.alu_op    = OP_ADD;
      end
      S_R_EXEC: begin
        ctrl_d.sel_src_a = 1'b1;
        ctrl_d.alu_op    = r_alu_op;
      end
      S_R_WB: begin
        ctrl_d.enable_rf = 1'b1;
        ctrl_d.sel_rf_wr = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_d.sel_src_a   = 1'b1;
        ctrl_d.sel_src_b   = 2'b10;
        ctrl_d.sel_imm_ext = (opcode == 6'h0D) || (opcode == 6'h0F);
        ctrl_d.alu_op      = (opcode == 6'h0D) ? OP_OR :
                             (opcode == 6'h0F) ? OP_LUI : OP_ADD;
      end
      S_I_WB: begin
        ctrl_d.enable_rf   = 1'b1;
        ctrl_d.sel_imm_ext = ctrl_q.sel_imm_ext;
        ctrl_d.alu_op      = ctrl_q.alu_op;
      end
      S_MEM_ADDR: begin
        ctrl_d.sel_src_a = 1'b1;
        ctrl_d.sel_src_b = 2'b10;
        ctrl_d.alu_op    = OP_ADD;
      end
      S_MEM_READ:  ctrl_d.sel_addr = 1'b1;
      S_MEM_WB: begin
        ctrl_d.enable_rf = 1'b1;
        ctrl_d.sel_rf_wd = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.sel_addr   = 1'b1;
        ctrl_d.enable_mem = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.sel_src_a = 1'b1;
        ctrl_d.alu_op    = OP_SUB;
        ctrl_d.pc_src    = 2'b01;
      end
      S_JUMP: begin
        ctrl_d.enable_pc = 1'b1;
        ctrl_d.pc_src    = 2'b10;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      br_ne_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      br_ne_q <= br_ne_d;
    end
  end

  // zero is only meaningful while the ALU compares A and B in BRANCH.
  assign enable_PC          = ctrl_q.enable_pc | ((state_q == S_BRANCH) & (br_ne_q ^ zero));
  assign Selector_Addr      = ctrl_q.sel_addr;
  assign enable_MemSys      = ctrl_q.enable_mem;
  assign enable_RegIns      = ctrl_q.enable_ir;
  assign enable_RF          = ctrl_q.enable_rf;
  assign Selector_RF_WR     = ctrl_q.sel_rf_wr;
  assign Selector_RF_WD     = ctrl_q.sel_rf_wd;
  assign Selector_ALU_Src_A = ctrl_q.sel_src_a;
  assign Selector_ALU_Src_B = ctrl_q.sel_src_b;
  assign Selector_Imm_Ext   = ctrl_q.sel_imm_ext;
  assign Selector_ALU_Op    = ctrl_q.alu_op;
  assign Selector_PC_Source = ctrl_q.pc_src;
  assign halted             = ctrl_q.halted;
  assign state_o            = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class through
// its state sequence and checks the control word with immediate assertions.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF;
  logic       Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_Imm_Ext, halted;
  logic [1:0] Selector_ALU_Src_B, Selector_PC_Source;
  logic [2:0] Selector_ALU_Op;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;
  int mem_pulses;

  localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2;
  localparam logic [3:0] ST_R_EXEC = 4'd3, ST_R_WB = 4'd4,  ST_I_EXEC = 4'd5, ST_I_WB = 4'd6;
  localparam logic [3:0] ST_MEM_ADDR = 4'd7, ST_MEM_READ = 4'd8, ST_MEM_WB = 4'd9;
  localparam logic [3:0] ST_MEM_WRITE = 4'd10, ST_BRANCH = 4'd11, ST_JUMP = 4'd12, ST_HALT = 4'd13;

  multicycle_control_unit #(.TEXT_BASE(32'h0040_0000), .STATE_W(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .opcode             (opcode),
    .funct              (funct),
    .zero               (zero),
    .enable_PC          (enable_PC),
    .Selector_Addr      (Selector_Addr),
    .enable_MemSys      (enable_MemSys),
    .enable_RegIns      (enable_RegIns),
    .enable_RF          (enable_RF),
    .Selector_RF_WR     (Selector_RF_WR),
    .Selector_RF_WD     (Selector_RF_WD),
    .Selector_ALU_Src_A (Selector_ALU_Src_A),
    .Selector_ALU_Src_B (Selector_ALU_Src_B),
    .Selector_Imm_Ext   (Selector_Imm_Ext),
    .Selector_ALU_Op    (Selector_ALU_Op),
    .Selector_PC_Source (Selector_PC_Source),
    .halted             (halted),
    .state_o            (state_o)
  );

  always #5 clk = ~clk;

  logic [17:0] ctrl_vec;
  assign ctrl_vec = {enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF,
                     Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_ALU_Src_B,
                     Selector_Imm_Ext, Selector_ALU_Op, Selector_PC_Source, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h20;
    zero   = 1'b0;

    // Reset held three cycles, released away from the clock edge.
    repeat (3) step();
    chk("reset_state", state_o, ST_IDLE);
    chk("reset_ctrl", ctrl_vec, 18'h0);
    reset = 1'b1;
    step();
    chk("fetch_state", state_o, ST_FETCH);
    chk("fetch_en_pc", enable_PC, 1'b1);
    chk("fetch_en_ir", enable_RegIns, 1'b1);
    chk("fetch_src_b", Selector_ALU_Src_B, 2'b01);
    chk("fetch_alu_op", Selector_ALU_Op, 3'b001);
    chk("fetch_addr", Selector_Addr, 1'b0);

    // ADDI
    opcode = 6'h08;
    step(); chk("addi_decode", state_o, ST_DECODE);
    chk("decode_src_b", Selector_ALU_Src_B, 2'b11);
    step(); chk("addi_exec", state_o, ST_I_EXEC);
    chk("addi_exec_alu", Selector_ALU_Op, 3'b001);
    chk("addi_exec_src", {Selector_ALU_Src_A, Selector_ALU_Src_B, Selector_Imm_Ext}, 4'b1100);
    chk("addi_exec_mem", enable_MemSys, 1'b0);
    step(); chk("addi_wb", state_o, ST_I_WB);
    chk("addi_wb_rf", {enable_RF, Selector_RF_WR, Selector_RF_WD, enable_MemSys}, 4'b1000);
    step(); chk("addi_refetch", state_o, ST_FETCH);

    // LUI: zero-extend and LUI op held through writeback
    opcode = 6'h0F;
    step(); step(); chk("lui_exec_alu", {Selector_Imm_Ext, Selector_ALU_Op}, 4'b1111);
    opcode = 6'h3A;
    step(); chk("lui_wb_held", {enable_RF, Selector_Imm_Ext, Selector_ALU_Op}, 5'b11111);
    step(); chk("lui_refetch", state_o, ST_FETCH);

    // R-type SUB
    opcode = 6'h00; funct = 6'h22;
    step(); chk("sub_decode", state_o, ST_DECODE);
    step(); chk("sub_exec", state_o, ST_R_EXEC);
    chk("sub_exec_ctrl", {Selector_ALU_Op, Selector_ALU_Src_A, Selector_ALU_Src_B}, 6'b010100);
    step(); chk("sub_wb", state_o, ST_R_WB);
    chk("sub_wb_ctrl", {enable_RF, Selector_RF_WR, Selector_RF_WD}, 3'b110);
    step(); chk("sub_refetch", state_o, ST_FETCH);

    // R-type NOR selects op 100
    funct = 6'h27;
    step(); step(); chk("nor_exec_alu", Selector_ALU_Op, 3'b100);
    step(); step(); chk("nor_refetch", state_o, ST_FETCH);

    // Illegal funct traps
    funct = 6'h3F;
    step(); chk("bad_funct_decode", state_o, ST_DECODE);
    step(); chk("bad_funct_halt", state_o, ST_HALT);
    chk("halt_ctrl", ctrl_vec, 18'h1);
    funct = 6'h20;
    step(); step(); chk("halt_sticky", {state_o, halted}, {ST_HALT, 1'b1});

    reset = 1'b0;
    #1 chk("halt_reset_async", {state_o, halted}, {ST_IDLE, 1'b0});
    step(); reset = 1'b1;
    step(); chk("halt_release", state_o, ST_FETCH);

    // LW: five cycles
    opcode = 6'h23;
    step(); chk("lw_decode", state_o, ST_DECODE);
    step(); chk("lw_addr", state_o, ST_MEM_ADDR);
    chk("lw_addr_ctrl", {Selector_ALU_Src_A, Selector_ALU_Src_B, Selector_Imm_Ext, Selector_ALU_Op}, 7'b1100001);
    step(); chk("lw_read", {state_o, Selector_Addr, enable_MemSys}, {ST_MEM_READ, 2'b10});
    step(); chk("lw_wb", state_o, ST_MEM_WB);
    chk("lw_wb_ctrl", {enable_RF, Selector_RF_WR, Selector_RF_WD}, 3'b101);
    step(); chk("lw_refetch", state_o, ST_FETCH);

    // SW: four cycles, one write pulse
    opcode = 6'h2B;
    mem_pulses = 0;
    step(); mem_pulses += int'(enable_MemSys);
    step(); mem_pulses += int'(enable_MemSys); chk("sw_addr", state_o, ST_MEM_ADDR);
    step(); mem_pulses += int'(enable_MemSys);
    chk("sw_write", {state_o, Selector_Addr, enable_MemSys}, {ST_MEM_WRITE, 2'b11});
    step(); mem_pulses += int'(enable_MemSys); chk("sw_refetch", state_o, ST_FETCH);
    chk("sw_pulse_count", mem_pulses, 1);

    // BEQ taken
    opcode = 6'h04; zero = 1'b1;
    step(); step(); chk("beq_state", state_o, ST_BRANCH);
    chk("beq_taken", {enable_PC, Selector_PC_Source, Selector_ALU_Op}, 6'b101010);
    step(); chk("beq_refetch", state_o, ST_FETCH);

    // BEQ not taken, then zero toggled inside BRANCH
    zero = 1'b0;
    step(); step(); chk("beq_not_taken", enable_PC, 1'b0);
    zero = 1'b1;
    #1 chk("beq_zero_live", enable_PC, 1'b1);
    step(); zero = 1'b1;

    // BNE: inverse sense
    opcode = 6'h05;
    step(); step(); chk("bne_zero1", enable_PC, 1'b0);
    zero = 1'b0;
    #1 chk("bne_zero0", {enable_PC, Selector_PC_Source}, 3'b101);
    step(); chk("bne_refetch", state_o, ST_FETCH);

    // J
    opcode = 6'h02;
    step(); step(); chk("j_state", state_o, ST_JUMP);
    chk("j_ctrl", {enable_PC, Selector_PC_Source, enable_RF, enable_MemSys}, 5'b11000);
    step(); chk("j_refetch", state_o, ST_FETCH);

    // Unknown opcode traps
    opcode = 6'h3F;
    step(); step(); chk("bad_opcode_halt", {state_o, halted}, {ST_HALT, 1'b1});
    reset = 1'b0; step(); reset = 1'b1; step();
    chk("bad_opcode_release", state_o, ST_FETCH);

    // Reset during MEM_WRITE aborts the store immediately
    opcode = 6'h2B;
    step(); step(); step();
    chk("abort_pre", {state_o, enable_MemSys}, {ST_MEM_WRITE, 1'b1});
    reset = 1'b0;
    #1 chk("abort_mem_low", enable_MemSys, 1'b0);
    chk("abort_state", state_o, ST_IDLE);
    chk("abort_ctrl", ctrl_vec, 18'h0);
    step(); reset = 1'b1;
    step(); chk("abort_resume", {state_o, enable_PC, enable_RegIns}, {ST_FETCH, 2'b11});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the multicycle MIPS Data_Path one instruction at a time.
- Inputs: the instruction register's opcode and funct fields, plus the ALU zero flag.
- Outputs: every enable and mux selector the datapath consumes.
- Sits directly upstream of Data_Path; together they form the core that drives GPIO_o.

Parameters:
- TEXT_BASE, 32'h0040_0000, documentation only (the PC reset value lives in the datapath); no RTL effect.
- STATE_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag, valid in the BRANCH state
- enable_PC  output  1  PC write enable
- Selector_Addr  output  1  memory address select: 0 = PC, 1 = ALUOut
- enable_MemSys  output  1  memory write enable
- enable_RegIns  output  1  instruction register load
- enable_RF  output  1  register file write enable
- Selector_RF_WR  output  1  write register: 0 = rt, 1 = rd
- Selector_RF_WD  output  1  write data: 0 = ALUOut, 1 = MDR
- Selector_ALU_Src_A  output  1  0 = PC, 1 = A
- Selector_ALU_Src_B  output  2  00 = B, 01 = const 4, 10 = ext imm, 11 = signext imm<<2
- Selector_Imm_Ext  output  1  0 = sign extend, 1 = zero extend
- Selector_ALU_Op  output  3  000 AND, 001 ADD, 010 SUB, 011 OR, 100 NOR, 101 SLL, 110 SRL, 111 LUI
- Selector_PC_Source  output  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}
- halted  output  1  illegal instruction trap
- state_o  output  4  current state, for debug

Behaviour:
- Reset (reset = 0, asynchronous): state <= IDLE immediately.
  - All enables 0, all selectors 0, halted 0.
- State sequence:
  - IDLE -> FETCH on the first clk edge after reset deasserts.
- Outputs are decoded from the state register only, with one exception:
  - In BRANCH, enable_PC = (BEQ & zero) | (BNE & ~zero).
- Unlisted outputs in any state = 0.
- FETCH:
  - enable_PC = 1, enable_RegIns = 1, Selector_Addr = 0.
  - Src_A = 0, Src_B = 01, ALU_Op = ADD, PC_Source = 00.
  - -> DECODE.
- DECODE:
  - Src_A = 0, Src_B = 11, ALU_Op = ADD (branch target into ALUOut).
  - Dispatch on opcode:
    - 0x00 -> R_EXEC if funct is in {0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x27, 0x00, 0x02}, else HALT.
    - 0x08 / 0x09 / 0x0D / 0x0F -> I_EXEC.
    - 0x23 / 0x2B -> MEM_ADDR.
    - 0x04 / 0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - Any other opcode -> HALT.
- R_EXEC:
  - Src_A = 1, Src_B = 00.
  - ALU_Op from funct: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 27 NOR, 00 SLL, 02 SRL.
  - -> R_WB.
- R_WB: enable_RF = 1, RF_WR = 1, RF_WD = 0 -> FETCH.
- I_EXEC:
  - Src_A = 1, Src_B = 10.
  - ADDI / ADDIU: ADD, Imm_Ext = 0.
  - ORI: OR, Imm_Ext = 1.
  - LUI: LUI, Imm_Ext = 1.
  - -> I_WB.
- I_WB:
  - enable_RF = 1, RF_WR = 0, RF_WD = 0.
  - Imm_Ext and ALU_Op held at their I_EXEC values.
  - -> FETCH.
- MEM_ADDR: Src_A = 1, Src_B = 10, ADD, Imm_Ext = 0 -> MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: Selector_Addr = 1 -> MEM_WB.
- MEM_WB: enable_RF = 1, RF_WR = 0, RF_WD = 1 -> FETCH.
- MEM_WRITE: Selector_Addr = 1, enable_MemSys = 1 -> FETCH.
- BRANCH: Src_A = 1, Src_B = 00, SUB, PC_Source = 01 -> FETCH.
- JUMP: enable_PC = 1, PC_Source = 10 -> FETCH.
- HALT:
  - halted = 1, all enables 0.
  - Terminal; only reset exits.
- Latency in cycles, counted from the FETCH cycle:
  - R-type 4, I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3.
- opcode, funct and zero are sampled only in the states listed above.
  - They may change freely in all other states (the IR updates at the end of FETCH).
- Reset asserted mid-instruction aborts the instruction in the same cycle.
  - No write enable may be observed high after reset falls.
- Unused state encodings -> IDLE on the next edge, with all outputs 0.

Test Plan:
- Reset release: hold reset = 0 for 3 cycles, then 1.
  - Required: state_o reads IDLE, then FETCH.
  - FETCH cycle has enable_PC = 1, enable_RegIns = 1, Src_B = 01, ALU_Op = 001.
- ADDI (opcode 0x08):
  - Required: FETCH -> DECODE -> I_EXEC -> I_WB -> FETCH, 4 cycles.
  - I_WB has enable_RF = 1, RF_WR = 0, RF_WD = 0.
  - enable_MemSys = 0 throughout.
- R-type SUB (opcode 0x00, funct 0x22):
  - R_EXEC has ALU_Op = 010, Src_A = 1, Src_B = 00.
  - R_WB has RF_WR = 1.
  - Then repeat with funct 0x3F: required DECODE -> HALT, halted = 1.
- LW (0x23), then SW (0x2B):
  - LW takes 5 cycles, with MEM_WB RF_WD = 1.
  - SW takes 4 cycles, with a single enable_MemSys pulse and Selector_Addr = 1.
- BEQ (0x04) with zero = 1, then zero = 0:
  - zero = 1: enable_PC = 1, PC_Source = 01.
  - zero = 0: enable_PC = 0.
  - BNE (0x05) gives the inverse result.
  - J (0x02): enable_PC = 1, PC_Source = 10.
- Drop reset to 0 during MEM_WRITE:
  - enable_MemSys falls in the same timestep.
  - state_o = IDLE; after release, fetch resumes.
